// File: rtl/adc_ser_pkg.sv
// adc_ser_pkg: shared definitions for the ADC serial transmitter.
// Provides a constant-evaluable clog2, the bit-counter width and
// frame-high length helpers (both derived from the word width), and the
// transmitter state enumeration.
package adc_ser_pkg;

    // Ceiling log2; evaluates to 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            w = w + 1;
        end
        return w;
    endfunction

    // Width of the bit counter that runs 0..numout-1 (never narrower than 1).
    function automatic int bit_cnt_w(input int numout);
        return (clog2(numout) < 1) ? 1 : clog2(numout);
    endfunction

    // Number of leading bits of each frame during which FR is high.
    function automatic int fr_high(input int numout);
        return numout / 2;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/adc_ser_tx_if.sv
// adc_ser_tx_if: parallel word handshake into the serial transmitter.
//   DIN        parallel word (NUMOUT bits)
//   DIN_VALID  DIN holds a word to transfer
//   DIN_READY  transmitter holding register is empty
// A transfer happens on a rising clk edge where DIN_VALID & DIN_READY.
interface adc_ser_tx_if #(
    parameter int NUMOUT = 8
);
    logic [NUMOUT-1:0] DIN;
    logic              DIN_VALID;
    logic              DIN_READY;

    modport master (output DIN, output DIN_VALID, input  DIN_READY);
    modport slave  (input  DIN, input  DIN_VALID, output DIN_READY);
endinterface

// File: rtl/adc_ser_tx_piso_shift.sv
// piso_shift: parallel-load, serial-out shift register.
//   clk, rst    clock and synchronous active-high reset (clears register)
//   load        load load_data (takes priority over shift_en)
//   load_data   word to load
//   shift_en    advance to the next bit
//   sout        current serial bit, taken straight from a register bit
// MSB_FIRST=1 emits bit NUMOUT-1 first; MSB_FIRST=0 emits bit 0 first.
module piso_shift #(
    parameter int NUMOUT    = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [NUMOUT-1:0] load_data,
    input  logic              shift_en,
    output logic              sout
);

    logic [NUMOUT-1:0] sr_r;

    // Shift register: reset, parallel load, or shift toward the output end.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_r <= '0;
        end else if (load) begin
            sr_r <= load_data;
        end else if (shift_en) begin
            sr_r <= MSB_FIRST ? {sr_r[NUMOUT-2:0], 1'b0} : {1'b0, sr_r[NUMOUT-1:1]};
        end else begin
            sr_r <= sr_r;
        end
    end

    assign sout = MSB_FIRST ? sr_r[NUMOUT-1] : sr_r[0];

endmodule

// File: rtl/adc_ser_tx.sv
// adc_ser_tx: parallel-to-serial framed transmitter (FR / DCI / D).
//   clk, rst       system clock (one serial bit per cycle), sync active-high reset
//   EN             1 = stream; 0 = finish the current frame then idle
//   bus (slave)    DIN / DIN_VALID / DIN_READY word handshake
//   FR             high for the first NUMOUT/2 bits of each frame
//   DCI            bit clock, 1 on even bit positions, edge-aligned to D
//   D              serial data
//   BUSY           1 while running
//   UNDERFLOW      sticky flag, set when IDLE_WORD is substituted
//   UNDERFLOW_CNT  saturating count of substituted words
// All outputs come straight from registers. The bit counter k names the bit
// that is visible on D during the current cycle.
module adc_ser_tx
    import adc_ser_pkg::*;
#(
    parameter int              NUMOUT    = 8,
    parameter bit              MSB_FIRST = 1'b1,
    parameter logic [NUMOUT-1:0] IDLE_WORD = '0,
    parameter int              CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EN,
    adc_ser_tx_if.slave       bus,
    output logic              FR,
    output logic              DCI,
    output logic              D,
    output logic              BUSY,
    output logic              UNDERFLOW,
    output logic [CNT_W-1:0]  UNDERFLOW_CNT
);

    localparam int              KW      = bit_cnt_w(NUMOUT);
    localparam logic [KW-1:0]   K_LAST  = KW'(NUMOUT - 1);
    localparam logic [KW-1:0]   K_HALF  = KW'(fr_high(NUMOUT));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e            state_r, state_s;
    logic [KW-1:0]     k_r, k_s;
    logic [NUMOUT-1:0] hold_r;
    logic              hold_full_r, hold_full_s;
    logic              din_ready_r;
    logic              fr_r, dci_r, busy_r;
    logic              uf_r;
    logic [CNT_W-1:0]  uf_cnt_r;

    logic              accept_s;
    logic              load_s;
    logic [NUMOUT-1:0] load_word_s;
    logic              shift_s;
    logic              consume_s;
    logic              underflow_s;
    logic              sout_s;

    assign accept_s = bus.DIN_VALID & din_ready_r;

    // Next-state / datapath control. Loads happen only from IDLE or at the
    // frame boundary; leaving RUN loads zero so D reads 0 while idle.
    always_comb begin
        state_s     = state_r;
        k_s         = k_r;
        load_s      = 1'b0;
        load_word_s = hold_r;
        shift_s     = 1'b0;
        consume_s   = 1'b0;
        underflow_s = 1'b0;
        case (state_r)
            IDLE: begin
                k_s = '0;
                if (EN && hold_full_r) begin
                    load_s    = 1'b1;
                    consume_s = 1'b1;
                    state_s   = RUN;
                end else begin
                    state_s   = IDLE;
                end
            end
            RUN: begin
                if (k_r == K_LAST) begin
                    k_s = '0;
                    if (!EN) begin
                        state_s     = IDLE;
                        load_s      = 1'b1;
                        load_word_s = '0;
                    end else if (hold_full_r) begin
                        load_s    = 1'b1;
                        consume_s = 1'b1;
                    end else begin
                        // A word accepted on this same edge is not visible yet.
                        load_s      = 1'b1;
                        load_word_s = IDLE_WORD;
                        underflow_s = 1'b1;
                    end
                end else begin
                    k_s     = k_r + KW'(1);
                    shift_s = 1'b1;
                end
            end
            default: begin
                state_s     = IDLE;
                k_s         = '0;
                load_s      = 1'b1;
                load_word_s = '0;
            end
        endcase
    end

    // Holding-register occupancy after this edge; consume and accept are
    // mutually exclusive because READY is only high while empty.
    always_comb begin
        hold_full_s = hold_full_r;
        if (consume_s) begin
            hold_full_s = 1'b0;
        end else if (accept_s) begin
            hold_full_s = 1'b1;
        end else begin
            hold_full_s = hold_full_r;
        end
    end

    // State, bit counter and the registered framing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            k_r     <= '0;
            fr_r    <= 1'b0;
            dci_r   <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            k_r     <= k_s;
            fr_r    <= (state_s == RUN) && (k_s < K_HALF);
            dci_r   <= (state_s == RUN) && !k_s[0];
            busy_r  <= (state_s == RUN);
        end
    end

    // Holding register and its registered READY (no same-cycle bypass).
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_r      <= '0;
            hold_full_r <= 1'b0;
            din_ready_r <= 1'b1;
        end else begin
            if (accept_s) begin
                hold_r <= bus.DIN;
            end else begin
                hold_r <= hold_r;
            end
            hold_full_r <= hold_full_s;
            din_ready_r <= !hold_full_s;
        end
    end

    // Sticky underflow flag and saturating substitution counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            uf_r     <= 1'b0;
            uf_cnt_r <= '0;
        end else if (underflow_s) begin
            uf_r     <= 1'b1;
            uf_cnt_r <= (uf_cnt_r == CNT_MAX) ? uf_cnt_r : uf_cnt_r + CNT_W'(1);
        end else begin
            uf_r     <= uf_r;
            uf_cnt_r <= uf_cnt_r;
        end
    end

    piso_shift #(
        .NUMOUT    (NUMOUT),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk       (clk),
        .rst       (rst),
        .load      (load_s),
        .load_data (load_word_s),
        .shift_en  (shift_s),
        .sout      (sout_s)
    );

    assign bus.DIN_READY = din_ready_r;
    assign FR            = fr_r;
    assign DCI           = dci_r;
    assign D             = sout_s;
    assign BUSY          = busy_r;
    assign UNDERFLOW     = uf_r;
    assign UNDERFLOW_CNT = uf_cnt_r;

endmodule

// File: tb/tb_adc_ser_tx.sv
// Bench for adc_ser_tx. Two instances share one stimulus stream:
//   A: MSB first, IDLE_WORD 8'h00, CNT_W 4  (saturates at 15)
//   B: LSB first, IDLE_WORD 8'h6A, CNT_W 16
// A transaction-level model (current frame word, bit position, holding slot)
// predicts every output each cycle; directed sections pin literal streams.
module tb_adc_ser_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;

    logic        fr_a, dci_a, d_a, busy_a, uf_a;
    logic [3:0]  cnt_a;
    logic        fr_b, dci_b, d_b, busy_b, uf_b;
    logic [15:0] cnt_b;

    int tests = 0;
    int fails = 0;

    adc_ser_tx_if #(.NUMOUT(8)) bus_a ();
    adc_ser_tx_if #(.NUMOUT(8)) bus_b ();

    assign bus_a.DIN       = din;
    assign bus_a.DIN_VALID = din_valid;
    assign bus_b.DIN       = din;
    assign bus_b.DIN_VALID = din_valid;

    adc_ser_tx #(.NUMOUT(8), .MSB_FIRST(1'b1), .IDLE_WORD(8'h00), .CNT_W(4)) dut_a (
        .clk(clk), .rst(rst), .EN(en), .bus(bus_a),
        .FR(fr_a), .DCI(dci_a), .D(d_a), .BUSY(busy_a),
        .UNDERFLOW(uf_a), .UNDERFLOW_CNT(cnt_a)
    );

    adc_ser_tx #(.NUMOUT(8), .MSB_FIRST(1'b0), .IDLE_WORD(8'h6A), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .EN(en), .bus(bus_b),
        .FR(fr_b), .DCI(dci_b), .D(d_b), .BUSY(busy_b),
        .UNDERFLOW(uf_b), .UNDERFLOW_CNT(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit        m_valid = 1'b0;
    bit        m_run, m_hold_full, m_ready, m_uf;
    int        m_k, m_cnt_a, m_cnt_b;
    bit [7:0]  m_hold, m_wa, m_wb;

    always @(posedge clk) begin
        bit       acc, took;
        bit [7:0] acc_word;
        if (rst) begin
            m_valid = 1'b1;
            m_run = 1'b0; m_k = 0; m_hold_full = 1'b0; m_ready = 1'b1;
            m_uf = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
            m_wa = 8'h00; m_wb = 8'h00; m_hold = 8'h00;
        end else if (m_valid) begin
            acc = din_valid && m_ready;
            acc_word = din;
            took = 1'b0;
            if (!m_run) begin
                if (en && m_hold_full) begin
                    m_wa = m_hold; m_wb = m_hold; took = 1'b1;
                    m_run = 1'b1; m_k = 0;
                end
            end else if (m_k == 7) begin
                m_k = 0;
                if (!en) begin
                    m_run = 1'b0;
                end else if (m_hold_full) begin
                    m_wa = m_hold; m_wb = m_hold; took = 1'b1;
                end else begin
                    m_wa = 8'h00; m_wb = 8'h6A; m_uf = 1'b1;
                    if (m_cnt_a < 15) m_cnt_a++;
                    if (m_cnt_b < 65535) m_cnt_b++;
                end
            end else begin
                m_k++;
            end
            if (took) m_hold_full = 1'b0;
            else if (acc) begin
                m_hold_full = 1'b1;
                m_hold = acc_word;
            end
            m_ready = !m_hold_full;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("fr_a",    64'(fr_a),   64'(m_run && m_k < 4));
            chk("dci_a",   64'(dci_a),  64'(m_run && (m_k % 2 == 0)));
            chk("d_a",     64'(d_a),    64'(m_run ? m_wa[7 - m_k] : 1'b0));
            chk("busy_a",  64'(busy_a), 64'(m_run));
            chk("ready_a", 64'(bus_a.DIN_READY), 64'(m_ready));
            chk("uf_a",    64'(uf_a),   64'(m_uf));
            chk("cnt_a",   64'(cnt_a),  64'(m_cnt_a));
            chk("fr_b",    64'(fr_b),   64'(m_run && m_k < 4));
            chk("dci_b",   64'(dci_b),  64'(m_run && (m_k % 2 == 0)));
            chk("d_b",     64'(d_b),    64'(m_run ? m_wb[m_k] : 1'b0));
            chk("busy_b",  64'(busy_b), 64'(m_run));
            chk("ready_b", 64'(bus_b.DIN_READY), 64'(m_ready));
            chk("uf_b",    64'(uf_b),   64'(m_uf));
            chk("cnt_b",   64'(cnt_b),  64'(m_cnt_b));
        end
    end

    // ---------------- directed helpers ----------------
    task automatic send(input logic [7:0] w);
        int t;
        din = w;
        din_valid = 1'b1;
        t = 0;
        while (bus_a.DIN_READY !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("send_timeout", 64'(0), 64'(1));
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // Waits for a frame start on A, then samples n bits (first bit ends up MSB).
    task automatic collect(input int n, input int drop_at,
                           output logic [63:0] da, output logic [63:0] db,
                           output logic [63:0] fv, output logic [63:0] dv);
        int t;
        da = '0; db = '0; fv = '0; dv = '0;
        t = 0;
        while (fr_a !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            chk("frame_start_timeout", 64'(0), 64'(1));
            return;
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            da = {da[62:0], d_a};
            db = {db[62:0], d_b};
            fv = {fv[62:0], fr_a};
            dv = {dv[62:0], dci_a};
            if (i == drop_at) en = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        en = 1'b0;
        din_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_fr",    64'(fr_a),   64'(0));
        chk("rst_dci",   64'(dci_a),  64'(0));
        chk("rst_d",     64'(d_a),    64'(0));
        chk("rst_busy",  64'(busy_a), 64'(0));
        chk("rst_ready", 64'(bus_a.DIN_READY), 64'(1));
        chk("rst_uf",    64'(uf_a),   64'(0));
        chk("rst_cnt_a", 64'(cnt_a),  64'(0));
        chk("rst_cnt_b", 64'(cnt_b),  64'(0));
        rst = 1'b0;
    endtask

    logic [63:0] da, db, fv, dv;
    logic        or_d;

    initial begin
        do_reset();

        // Single word 8'hA5, then an underflow frame.
        en = 1'b1;
        fork
            send(8'hA5);
            collect(16, -1, da, db, fv, dv);
        join
        chk("single_d",     da[15:0], 64'h0000_0000_0000_A500);
        chk("single_fr",    fv[15:0], 64'h0000_0000_0000_F0F0);
        chk("single_dci",   dv[15:0], 64'h0000_0000_0000_AAAA);
        chk("idle_word_b",  db[7:0],  64'h56);
        chk("single_uf",    64'(uf_a),  64'(1));
        chk("single_cnt",   64'(cnt_a), 64'(1));

        // Back-to-back words with VALID held.
        do_reset();
        en = 1'b1;
        fork
            begin
                send(8'h01);
                send(8'hFE);
                send(8'h3C);
            end
            collect(24, -1, da, db, fv, dv);
        join
        chk("b2b_d",     da[23:0],  64'h01FE3C);
        chk("b2b_fr",    fv[23:0],  64'hF0F0F0);
        chk("lsb_first", db[23:16], 64'h80);
        chk("b2b_uf",    64'(uf_a), 64'(0));

        // EN drop mid-frame with a word waiting.
        do_reset();
        en = 1'b1;
        fork
            begin
                send(8'hF0);
                send(8'h0F);
            end
            collect(8, 3, da, db, fv, dv);
        join
        chk("drop_d", da[7:0], 64'hF0);
        repeat (3) begin
            @(negedge clk);
            chk("drop_idle_fr",    64'(fr_a),   64'(0));
            chk("drop_idle_d",     64'(d_a),    64'(0));
            chk("drop_idle_busy",  64'(busy_a), 64'(0));
            chk("drop_idle_ready", 64'(bus_a.DIN_READY), 64'(0));
        end
        en = 1'b1;
        collect(8, -1, da, db, fv, dv);
        chk("resume_d", da[7:0], 64'h0F);

        // Counter saturation over 20 underflow frames.
        do_reset();
        en = 1'b1;
        fork
            send(8'h55);
            collect(8, -1, da, db, fv, dv);
        join
        chk("sat_first", da[7:0], 64'h55);
        or_d = 1'b0;
        repeat (160) begin
            @(negedge clk);
            or_d = or_d | d_a;
        end
        chk("sat_d_zero", 64'(or_d),  64'(0));
        chk("sat_cnt_a",  64'(cnt_a), 64'(15));
        chk("sat_uf",     64'(uf_a),  64'(1));
        chk("sat_cnt_b",  64'(cnt_b), 64'(20));

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            en        = ($urandom_range(0, 7) != 0);
            din_valid = $urandom_range(0, 1) == 1;
            din       = 8'($urandom);
            rst       = ($urandom_range(0, 299) == 0);
        end

        // Reset in the middle of traffic.
        en = 1'b1;
        din_valid = 1'b1;
        repeat (5) @(negedge clk);
        do_reset();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_ser_tx.md
Name: adc_ser_tx

Overview:
- Parallel-to-serial transmitter, the transmit-side counterpart of the ADC LVDS deserializer.
- Takes NUMOUT-bit words over a valid/ready handshake and emits the same three-wire framed stream the receiver consumes: FR (frame), DCI (bit clock), D (data).
- Used as an ADC emulator on the test fixture and as the serial front end toward the DAC path.
- Single clock domain. Output DDR/phase alignment to pins is done downstream and is out of scope.

Parameters:
- NUMOUT, 8, word width in bits; even, >= 4.
- MSB_FIRST, 1, 1 = bit NUMOUT-1 sent first; 0 = bit 0 first.
- IDLE_WORD, 0, word transmitted on underflow.
- CNT_W, 16, width of underflow counter.

Ports:
- clk  in  1  system clock; one serial bit per cycle.
- rst  in  1  synchronous, active-high reset.
- EN  in  1  1 = stream; 0 = finish current frame, then go idle.
- DIN  in  NUMOUT  parallel word.
- DIN_VALID  in  1  DIN valid.
- DIN_READY  out  1  holding register empty; transfer on VALID&READY at posedge clk.
- FR  out  1  frame; high for the first NUMOUT/2 bits of each word.
- DCI  out  1  bit clock, edge-aligned to D; toggles every clk while running.
- D  out  1  serial data.
- BUSY  out  1  1 while in RUN.
- UNDERFLOW  out  1  sticky; set when IDLE_WORD is substituted.
- UNDERFLOW_CNT  out  CNT_W  saturating count of substituted words.

Behaviour:
- Reset (synchronous, active-high), values after the reset edge:
  - FR=0, DCI=0, D=0, BUSY=0, DIN_READY=1, UNDERFLOW=0, UNDERFLOW_CNT=0.
  - Holding register empty; state IDLE; bit counter 0.
  - Reset mid-frame aborts the frame and discards the shift and holding contents.
- Storage: 1-deep holding register plus NUMOUT-bit shift register, bit counter 0..NUMOUT-1.
- DIN_READY = holding empty, registered. There is no bypass: in the cycle the holding word is consumed, DIN_READY stays 0 and rises the next cycle.
- All outputs are registered. In the cycle where the bit counter = k, D is bit k of the frame (per MSB_FIRST).
  - FR = (k < NUMOUT/2).
  - DCI = ~k[0], so DCI is 1 on bit 0 and FR rises with a DCI rising edge.
- State IDLE:
  - Outputs FR/DCI/D = 0.
  - If EN=1 and holding is full: load shift register from holding, empty holding, go to RUN with k=0.
  - The first bit appears one clk after the load edge. Minimum accept-to-first-bit latency is 2 clk.
- State RUN:
  - Each clk: k <= k+1 and shift the register.
  - At k = NUMOUT-1 (frame boundary):
    - EN=0: go to IDLE; outputs 0 next cycle; the holding word is retained.
    - EN=1, holding full: load the word, k <= 0; frames are back-to-back with no gap.
    - EN=1, holding empty: load IDLE_WORD, k <= 0, set UNDERFLOW, UNDERFLOW_CNT += 1, saturating at 2^CNT_W-1.
  - EN changes at any k other than NUMOUT-1 have no effect until the boundary.
- Simultaneous accept and boundary with holding empty: the new word is not yet visible, so the underflow path is taken. The accepted word is sent in the following frame.
- Throughput: one word per NUMOUT clk. FR period = NUMOUT clk, 50% duty cycle.
- UNDERFLOW and UNDERFLOW_CNT clear only on rst.

Decomposition:
- Package adc_ser_pkg: function clog2, bit-counter width constant, FR_HIGH = NUMOUT/2, state enum {IDLE, RUN}.
- One natural sub-module: piso_shift. It holds the NUMOUT-bit parallel-load shift register with load, shift-enable and MSB_FIRST, and outputs the current serial bit.
- Control, handshake and counters stay in the top level.

Test Plan:
- Reset check: assert rst for 3 clk mid-traffic -> next cycle FR=DCI=D=0, BUSY=0, DIN_READY=1, UNDERFLOW_CNT=0.
- Single word: NUMOUT=8, send DIN=8'hA5 with EN=1 -> D=1,0,1,0,0,1,0,1; FR=1,1,1,1,0,0,0,0; DCI=1,0,1,0,1,0,1,0. Then with no further word: D=0 x8, UNDERFLOW=1, UNDERFLOW_CNT=1.
- Back-to-back: send 8'h01, 8'hFE, 8'h3C with VALID held high -> 24 contiguous bits 00000001 11111110 00111100, FR period 8, UNDERFLOW stays 0, DIN_READY pulses once per frame.
- EN drop: deassert EN at k=3 of word 8'hF0 while 8'h0F waits in holding -> bits 4..7 complete, then IDLE with outputs 0 and DIN_READY=0. Reassert EN -> 8'h0F is sent after a 2-clk latency.
- LSB-first: MSB_FIRST=0, DIN=8'h01 -> D=1,0,0,0,0,0,0,0.
- Saturation: CNT_W=4, EN=1, no data for 20 frames -> UNDERFLOW_CNT stops at 15, UNDERFLOW=1, D=IDLE_WORD bits throughout.
